// File: rtl/led_status_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// led_status_ctrl_pkg
//   Shared definitions for the LED status driver: the 2-bit display mode
//   encodings (also used by the testbench) and small elaboration-time helpers
//   for the page arithmetic.
// ---------------------------------------------------------------------------
package led_status_ctrl_pkg;

   localparam logic [1:0] MODE_STATIC    = 2'd0;
   localparam logic [1:0] MODE_SCROLL    = 2'd1;
   localparam logic [1:0] MODE_HEARTBEAT = 2'd2;
   localparam logic [1:0] MODE_SNAP      = 2'd3;

   // Integer ceiling division, used to count the pages needed to show the
   // whole gp word with D data LEDs.
   function automatic int ceilDiv(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Width of the page index. A single page still needs a 1-bit port.
   function automatic int pageWidth(input int wordLen, input int nLeds);
      int nPages;
      nPages = ceilDiv(wordLen, nLeds - 1);
      return (nPages > 1) ? $clog2(nPages) : 1;
   endfunction

   // Modes in which the page index advances on the page tick.
   function automatic logic isScrolling(input logic [1:0] mode);
      return (mode == MODE_SCROLL) || (mode == MODE_SNAP);
   endfunction

endpackage

// File: rtl/led_status_ctrl_tick_div.sv
// ---------------------------------------------------------------------------
// tick_div
//   Free-running prescaler producing a one-cycle tick every PERIOD cycles.
//   Ports:
//     clk_i      core clock
//     rst_ni     async active-low reset, counter returns to 0
//     restart_i  synchronous restart: counter reloads 0, tick suppressed
//     tick_o     one-cycle pulse when the counter reaches PERIOD-1
// ---------------------------------------------------------------------------
module tick_div #(
   parameter int PERIOD = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic restart_i,
   output logic tick_o
);

   localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // A restart wins over a tick landing in the same cycle, so the caller
   // never sees a stale tick belonging to the interval it just abandoned.
   always_comb begin
      count_d = count_q + CW'(1);
      if (restart_i || (count_q == LAST)) begin
         count_d = '0;
      end
      tick_o = (count_q == LAST) && !restart_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/led_status_ctrl.sv
// ---------------------------------------------------------------------------
// led_status_ctrl
//   LED status driver between the core debug outputs and the board LEDs.
//   led[0] is a status LED, led[N_LEDS-1:1] show a page of D = N_LEDS-1 bits
//   of gp (live, or a snapshot), with static, scrolling, heartbeat and
//   snapshot modes plus a sticky exit flag that forces snapshot display.
//   Ports:
//     clk_i        core clock
//     rst_ni       async active-low reset
//     exit_i       core test-end flag (level)
//     gp_i         core gp register
//     mode_i       0 STATIC, 1 SCROLL, 2 HEARTBEAT, 3 SNAP
//     led_o        board LEDs, registered, polarity applied
//     page_o       page currently displayed, registered
//     exit_seen_o  sticky exit flag, cleared only by reset
// ---------------------------------------------------------------------------
module led_status_ctrl
   import led_status_ctrl_pkg::*;
#(
   parameter int WORD_LEN        = 32,
   parameter int N_LEDS          = 6,
   parameter int PAGE_CYCLES     = 9000000,
   parameter int BLINK_CYCLES    = 4500000,
   parameter bit DATA_ACTIVE_LOW = 1'b1,
   parameter bit STAT_ACTIVE_LOW = 1'b0
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic                                     exit_i,
   input  logic [WORD_LEN-1:0]                      gp_i,
   input  logic [1:0]                               mode_i,
   output logic [N_LEDS-1:0]                        led_o,
   output logic [pageWidth(WORD_LEN, N_LEDS)-1:0]   page_o,
   output logic                                     exit_seen_o
);

   localparam int D      = N_LEDS - 1;
   localparam int NPAGES = ceilDiv(WORD_LEN, D);
   localparam int PW     = pageWidth(WORD_LEN, N_LEDS);
   localparam int EXT_W  = NPAGES * D;

   localparam logic [PW-1:0]     PAGE_LAST = PW'(NPAGES - 1);
   localparam logic [N_LEDS-1:0] POL_MASK  = {{D{DATA_ACTIVE_LOW}}, STAT_ACTIVE_LOW};

   logic [1:0]          mode_q;
   logic [PW-1:0]       page_q,     page_d;
   logic [WORD_LEN-1:0] snapshot_q, snapshot_d;
   logic                exitSeen_q, exitSeen_d;
   logic                hb_q,       hb_d;
   logic [N_LEDS-1:0]   led_q,      led_d;

   logic [1:0]          modeEff;
   logic                exitRise;
   logic                restart;
   logic                pageTick;
   logic                hbTick;
   logic [WORD_LEN-1:0] gpSel;
   logic [EXT_W-1:0]    gpExt;
   logic [D-1:0]        window;
   logic [N_LEDS-1:0]   ledLit;

   // Page prescaler restarts with the page index; heartbeat prescaler never does.
   tick_div #(.PERIOD(PAGE_CYCLES)) uPageDiv (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .restart_i (restart),
      .tick_o    (pageTick)
   );

   tick_div #(.PERIOD(BLINK_CYCLES)) uHbDiv (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .restart_i (1'b0),
      .tick_o    (hbTick)
   );

   // Control: the exit level forces SNAP from its first cycle onward. A fresh
   // exit restarts the page even when the core was already in SNAP, and the
   // snapshot freezes once exit has been seen.
   always_comb begin
      exitRise   = exit_i && !exitSeen_q;
      modeEff    = (exitSeen_q || exit_i) ? MODE_SNAP : mode_i;
      restart    = (modeEff != mode_q) || exitRise;
      exitSeen_d = exitSeen_q || exit_i;
      hb_d       = hbTick ? !hb_q : hb_q;

      snapshot_d = snapshot_q;
      if (!exitSeen_q && (exitRise || ((modeEff == MODE_SNAP) && (mode_q != MODE_SNAP)))) begin
         snapshot_d = gp_i;
      end

      page_d = page_q;
      if (restart || !isScrolling(modeEff)) begin
         page_d = '0;
      end else if (pageTick) begin
         page_d = (page_q == PAGE_LAST) ? '0 : page_q + PW'(1);
      end
   end

   // Display: the word is zero-extended to a whole number of pages so bits
   // past WORD_LEN read as unlit. Within a page the lowest bit lands on the
   // top LED. Everything is built from next-state values so the LEDs, page
   // and status update on the same edge as the inputs that caused them.
   always_comb begin
      gpSel  = (modeEff == MODE_SNAP) ? snapshot_d : gp_i;
      gpExt  = EXT_W'(gpSel);
      window = D'(gpExt >> (int'(page_d) * D));

      ledLit = '0;
      for (int i = 0; i < D; i++) begin
         ledLit[1+i] = window[D-1-i];
      end
      if (modeEff == MODE_HEARTBEAT) begin
         ledLit[1] = hb_d;
      end
      ledLit[0] = exitSeen_d || ((modeEff == MODE_HEARTBEAT) && hb_d);

      led_d = ledLit ^ POL_MASK;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q     <= MODE_STATIC;
         page_q     <= '0;
         snapshot_q <= '0;
         exitSeen_q <= 1'b0;
         hb_q       <= 1'b0;
         led_q      <= POL_MASK;
      end else begin
         mode_q     <= modeEff;
         page_q     <= page_d;
         snapshot_q <= snapshot_d;
         exitSeen_q <= exitSeen_d;
         hb_q       <= hb_d;
         led_q      <= led_d;
      end
   end

   assign led_o       = led_q;
   assign page_o      = page_q;
   assign exit_seen_o = exitSeen_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_status_ctrl
//   Directed testbench for led_status_ctrl with N_LEDS=6, WORD_LEN=32,
//   PAGE_CYCLES=4, BLINK_CYCLES=3 (D=5, NPAGES=7). Data LEDs are active-low,
//   the status LED active-high, so all-unlit is 6'b111110.
// ---------------------------------------------------------------------------
module tb_led_status_ctrl;
   import led_status_ctrl_pkg::*;

   typedef struct {
      logic        exitIn;
      logic [31:0] gpIn;
      logic [1:0]  modeIn;
      logic [5:0]  expLed;
      logic [2:0]  expPage;
      logic        expExit;
   } vector_t;

   logic        clk    = 1'b0;
   logic        rstN   = 1'b1;
   logic        exitIn = 1'b0;
   logic [31:0] gpIn   = '0;
   logic [1:0]  modeIn = MODE_STATIC;
   logic [5:0]  ledOut;
   logic [2:0]  pageOut;
   logic        exitSeenOut;

   int testsRun    = 0;
   int testsFailed = 0;

   vector_t    vecs[15];
   logic [5:0] hbExp[10];

   // 10 ns core clock
   always #5 clk = ~clk;

   led_status_ctrl #(
      .WORD_LEN        (32),
      .N_LEDS          (6),
      .PAGE_CYCLES     (4),
      .BLINK_CYCLES    (3),
      .DATA_ACTIVE_LOW (1'b1),
      .STAT_ACTIVE_LOW (1'b0)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rstN),
      .exit_i      (exitIn),
      .gp_i        (gpIn),
      .mode_i      (modeIn),
      .led_o       (ledOut),
      .page_o      (pageOut),
      .exit_seen_o (exitSeenOut)
   );

   // Compare all three outputs against the expected values
   task automatic checkOutput(input string name, input logic [5:0] expLed,
                              input logic [2:0] expPage, input logic expExit);
      testsRun++;
      if (ledOut !== expLed) begin
         testsFailed++;
         $display("[TB] FAIL %s led: got %b, expected %b", name, ledOut, expLed);
      end
      testsRun++;
      if (pageOut !== expPage) begin
         testsFailed++;
         $display("[TB] FAIL %s page: got %0d, expected %0d", name, pageOut, expPage);
      end
      testsRun++;
      if (exitSeenOut !== expExit) begin
         testsFailed++;
         $display("[TB] FAIL %s exit_seen: got %b, expected %b", name, exitSeenOut, expExit);
      end
   endtask

   // Drive inputs for one clock and land 1 ns after the edge for sampling
   task automatic applyStimulus(input logic e, input logic [31:0] g, input logic [1:0] m);
      exitIn = e;
      gpIn   = g;
      modeIn = m;
      @(posedge clk);
      #1;
   endtask

   // Assert reset mid-cycle, check the outputs respond asynchronously,
   // then release on a falling edge so the next rising edge is edge 1
   task automatic doReset(input string name);
      rstN   = 1'b0;
      exitIn = 1'b0;
      gpIn   = '0;
      modeIn = MODE_STATIC;
      #2;
      checkOutput(name, 6'b111110, 3'd0, 1'b0);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   // Mode change to SNAP on the cycle the page tick is due (edge 5),
   // optionally together with exit rising
   task automatic simulSeq(input string name, input logic withExit);
      doReset({name, "_reset"});
      for (int e = 1; e <= 4; e++) begin
         applyStimulus(1'b0, 32'h0, MODE_SCROLL);
      end
      checkOutput({name, "_pre"}, 6'b111110, 3'd0, 1'b0);
      applyStimulus(withExit, 32'h15, MODE_SNAP);
      checkOutput({name, "_entry"}, {5'b01010, withExit}, 3'd0, withExit);
      for (int e = 6; e <= 8; e++) begin
         applyStimulus(1'b0, 32'h0, MODE_SNAP);
         checkOutput($sformatf("%s_hold%0d", name, e), {5'b01010, withExit}, 3'd0, withExit);
      end
      applyStimulus(1'b0, 32'h0, MODE_SNAP);
      checkOutput({name, "_step"}, {5'b11111, withExit}, 3'd1, withExit);
   endtask

   initial begin
      // Edge-by-edge vectors from reset release
      vecs[0]  = '{1'b0, 32'h0000_0015, MODE_STATIC,    6'b010100, 3'd0, 1'b0};
      vecs[1]  = '{1'b0, 32'hFFFF_FFE0, MODE_STATIC,    6'b111110, 3'd0, 1'b0};
      vecs[2]  = '{1'b0, 32'h0000_001F, MODE_STATIC,    6'b000000, 3'd0, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0001, MODE_STATIC,    6'b011110, 3'd0, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_03E0, MODE_SCROLL,    6'b111110, 3'd0, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_03E0, MODE_SCROLL,    6'b111110, 3'd0, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_03E0, MODE_SCROLL,    6'b111110, 3'd0, 1'b0};
      vecs[7]  = '{1'b0, 32'h0000_03E0, MODE_SCROLL,    6'b111110, 3'd0, 1'b0};
      vecs[8]  = '{1'b0, 32'h0000_0020, MODE_SCROLL,    6'b011110, 3'd1, 1'b0};
      vecs[9]  = '{1'b0, 32'h0000_0200, MODE_SCROLL,    6'b111100, 3'd1, 1'b0};
      vecs[10] = '{1'b0, 32'h0000_001F, MODE_SNAP,      6'b000000, 3'd0, 1'b0};
      vecs[11] = '{1'b0, 32'h0000_0000, MODE_SNAP,      6'b000000, 3'd0, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_0000, MODE_STATIC,    6'b111110, 3'd0, 1'b0};
      vecs[13] = '{1'b0, 32'h0000_0010, MODE_HEARTBEAT, 6'b111110, 3'd0, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_0010, MODE_HEARTBEAT, 6'b111101, 3'd0, 1'b0};

      // Heartbeat from reset, gp=0: hb toggles at edges 3, 6, 9; edge 10 is STATIC
      hbExp[0] = 6'b111110; hbExp[1] = 6'b111110; hbExp[2] = 6'b111101;
      hbExp[3] = 6'b111101; hbExp[4] = 6'b111101; hbExp[5] = 6'b111110;
      hbExp[6] = 6'b111110; hbExp[7] = 6'b111110; hbExp[8] = 6'b111101;
      hbExp[9] = 6'b111110;

      doReset("reset_initial");

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].exitIn, vecs[i].gpIn, vecs[i].modeIn);
         checkOutput($sformatf("vec%0d", i), vecs[i].expLed, vecs[i].expPage, vecs[i].expExit);
      end

      // Heartbeat phase and return to STATIC
      doReset("reset_hb");
      for (int e = 1; e <= 10; e++) begin
         applyStimulus(1'b0, 32'h0, (e == 10) ? MODE_STATIC : MODE_HEARTBEAT);
         checkOutput($sformatf("hb_edge%0d", e), hbExp[e-1], 3'd0, 1'b0);
      end

      // Full scroll through 7 pages and wrap; page 6 has bits 32..34 unlit
      doReset("reset_scroll");
      for (int e = 1; e <= 33; e++) begin
         int p;
         p = ((e - 1) / 4) % 7;
         applyStimulus(1'b0, 32'hFFFF_FFFF, MODE_SCROLL);
         checkOutput($sformatf("scroll_edge%0d", e),
                     (p == 6) ? 6'b001110 : 6'b000000, 3'(p), 1'b0);
      end

      // Reset while scrolling on page 1
      doReset("reset_mid_scroll");

      // Exit pulse, then later gp/mode/exit activity must be ignored
      applyStimulus(1'b0, 32'h1, MODE_SCROLL);
      checkOutput("exit_pre1", 6'b011110, 3'd0, 1'b0);
      applyStimulus(1'b0, 32'h1, MODE_SCROLL);
      checkOutput("exit_pre2", 6'b011110, 3'd0, 1'b0);
      applyStimulus(1'b1, 32'h1, MODE_SCROLL);
      checkOutput("exit_rise", 6'b011111, 3'd0, 1'b1);
      applyStimulus(1'b0, 32'h2, MODE_SCROLL);
      checkOutput("exit_gp2", 6'b011111, 3'd0, 1'b1);
      applyStimulus(1'b0, 32'hFFFF_FFFF, MODE_STATIC);
      checkOutput("exit_static", 6'b011111, 3'd0, 1'b1);
      applyStimulus(1'b1, 32'hFFFF_FFFF, MODE_HEARTBEAT);
      checkOutput("exit_held", 6'b011111, 3'd0, 1'b1);
      for (int e = 7; e <= 31; e++) begin
         int p;
         p = ((e - 3) / 4) % 7;
         applyStimulus(1'b1, 32'hFFFF_FFFF, MODE_SCROLL);
         checkOutput($sformatf("exit_scroll%0d", e),
                     (p == 0) ? 6'b011111 : 6'b111111, 3'(p), 1'b1);
      end

      // Reset clears the sticky exit
      doReset("reset_after_exit");

      // Mode change coinciding with the page tick, without and with exit
      simulSeq("simul_mode", 1'b0);
      simulSeq("simul_exit", 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
